img_stream_tx: RTL and testbench
================================

Name: img_stream_tx

Overview:
- Video stream transmitter: generates the vsync/hsync/valid/data pixel stream consumed by the image-processing blocks (3x3 window, sharpen and similar filters).
- Pulls 8-bit grayscale pixels from an upstream first-word-fall-through FIFO and frames them with programmable blanking timing.
- Sits between the frame-buffer read path and the processing chain; serves as both the bench stimulus source and the on-chip source.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run request; sampled only at frame boundaries
- src_empty  in  1  upstream FIFO empty
- src_data  in  8  upstream FIFO head word (FWFT)
- src_rd  out  1  FIFO pop strobe (combinational)
- post_img_vsync  out  1  vertical sync, active high
- post_img_hsync  out  1  horizontal sync, active high
- post_img_valid  out  1  active-pixel qualifier
- post_img_data  out  8  pixel value
- frame_done  out  1  one-cycle pulse on the last clock of each frame
- underflow  out  1  sticky; set on an active pixel with an empty FIFO

Behaviour:
- Reset: one clock with rst_n=0 at the posedge; synchronous and active-low. All outputs 0, counters 0, state IDLE. Reset mid-frame aborts the frame immediately with no partial-line completion.
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
  - Widths: $clog2 of each total.
- Region decodes, from the counter values:
  - hs = h_cnt < H_SYNC
  - vs = v_cnt < V_SYNC
  - act = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)
- FSM:
  - IDLE: counters held at 0, all stream outputs 0. Go to RUN when enable=1. The first RUN cycle has h_cnt=0, v_cnt=0.
  - RUN: counters advance every clock.
    - At the last frame cycle (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), assert frame_done.
    - If enable=1 at that cycle, stay in RUN and wrap.
    - If enable=0 at that cycle, go to IDLE.
    - enable dropping mid-frame has no effect until the frame ends.
- Pixel fetch:
  - src_rd = RUN & act & ~src_empty.
  - Output registers load one clock after the decode, so output latency from the counters is exactly 1 clock.
  - post_img_data <= src_data when src_rd, else 0.
- Underflow: RUN & act & src_empty sets underflow. That pixel is still emitted with valid=1 and data=0, so frame timing is never stretched. underflow clears only on reset.
- Blanking: post_img_data = 0 whenever valid=0. src_rd is never asserted outside act.
- frame_done is registered and aligned with the outputs, i.e. it pulses alongside the last output cycle.

Optional Feature:
- Macro: IMG_STREAM_TX_PATTERN_EN.
- When defined:
  - Extra input pattern_sel (1 bit).
  - With pattern_sel=1, data = (h_cnt - (H_SYNC+H_BP)) + (v_cnt - (V_SYNC+V_BP)), truncated to 8 bits, i.e. a diagonal gradient.
  - src_rd is held 0 and underflow is not updated.
  - pattern_sel is sampled at frame start only.
- When undefined: no port, no pattern logic; FIFO is the only data source.

Decomposition:
- Package img_stream_pkg:
  - pixel width constant PIX_W=8
  - FSM state typedef (IDLE, RUN)
  - function computing H_TOTAL/V_TOTAL and counter widths
- One sub-module: img_timing_gen.
  - Contains the h/v counters and hs/vs/act decodes, parameterised by the timing parameters, with a run input.
  - Reused later by the stream receiver/capture block.
- The top level holds the FSM, fetch, underflow and output registers.

Test Plan:
- Small timing (H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1); FIFO preloaded with 0..11; enable=1 -> per frame: 12 valid pixels 0..11 in raster order, hsync width 1, line period 7 clocks, vsync 1 line, frame_done once every 42 clocks.
- Same setup, enable dropped at cycle 10 -> current frame completes fully, then outputs stay 0 and no further src_rd.
- FIFO empty for the 6th active pixel -> that pixel is valid=1, data=0; underflow=1 thereafter; timing unchanged; later pixels resume from the FIFO.
- rst_n=0 asserted mid-line for one clock -> next posedge all outputs 0, state IDLE; frame restarts at h_cnt=0, v_cnt=0 if enable=1.
- Check every clock -> src_rd never high outside active region; data=0 whenever valid=0; output latency exactly 1 clock from decode.
- With IMG_STREAM_TX_PATTERN_EN defined and pattern_sel=1 -> row 0 = 0,1,2,3 and row 2 = 2,3,4,5; src_rd stays 0.

Source files
------------

// File: rtl/img_stream_pkg.sv
// Shared types and timing helpers for the image stream transmitter and its timing generator.
// Optional test-pattern source is enabled by the IMG_STREAM_TX_PATTERN_EN macro.
package img_stream_pkg;

  localparam int PIX_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int calc_total(input int sync_w, input int bp_w, input int act_w, input int fp_w);
    return sync_w + bp_w + act_w + fp_w;
  endfunction

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/img_stream_tx_if.sv
// FIFO-side and stream-side signals of the transmitter; master is the transmitter.
// pattern_sel exists only when IMG_STREAM_TX_PATTERN_EN is defined.
interface img_stream_tx_if import img_stream_pkg::*; ();

  logic             enable;
  logic             src_empty;
  logic [PIX_W-1:0] src_data;
  logic             src_rd;
  logic             post_img_vsync;
  logic             post_img_hsync;
  logic             post_img_valid;
  logic [PIX_W-1:0] post_img_data;
  logic             frame_done;
  logic             underflow;
`ifdef IMG_STREAM_TX_PATTERN_EN
  logic             pattern_sel;
`endif

  modport master (
    input  enable, src_empty, src_data,
`ifdef IMG_STREAM_TX_PATTERN_EN
    input  pattern_sel,
`endif
    output src_rd, post_img_vsync, post_img_hsync, post_img_valid,
    output post_img_data, frame_done, underflow
  );

  modport slave (
    output enable, src_empty, src_data,
`ifdef IMG_STREAM_TX_PATTERN_EN
    output pattern_sel,
`endif
    input  src_rd, post_img_vsync, post_img_hsync, post_img_valid,
    input  post_img_data, frame_done, underflow
  );

endinterface

// File: rtl/img_timing_gen.sv
// Raster h/v counters with sync and active-region decodes; counters sit at zero while run_i is low.
// Shared with the capture side, so it carries no stream-specific logic.
module img_timing_gen
  import img_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP),
  localparam int V_TOTAL = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP),
  localparam int HW      = cnt_width(H_TOTAL),
  localparam int VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          act_o
);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          h_last, v_last;
  int            h_i, v_i;

  assign h_last = (h_q == HW'(H_TOTAL - 1));
  assign v_last = (v_q == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !run_i) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_last) begin
      h_q <= '0;
      v_q <= v_last ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  // Decode in int so region bounds equal to the total cannot overflow the counter width.
  always_comb begin
    h_i   = int'(h_q);
    v_i   = int'(v_q);
    hs_o  = h_i < H_SYNC;
    vs_o  = v_i < V_SYNC;
    act_o = (h_i >= H_SYNC + H_BP) && (h_i < H_SYNC + H_BP + H_ACTIVE) &&
            (v_i >= V_SYNC + V_BP) && (v_i < V_SYNC + V_BP + V_ACTIVE);
  end

  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;

endmodule

// File: rtl/img_stream_tx.sv
// Video stream transmitter: frames FWFT FIFO pixels with blanking/sync, one clock behind the counters.
// Define IMG_STREAM_TX_PATTERN_EN to add a pattern_sel-selected diagonal gradient source.
module img_stream_tx
  import img_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic             clk,
  input logic             rst_n,
  img_stream_tx_if.master bus
);

  localparam int H_TOTAL = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             hs, vs, act;
  state_e           state_q;
  logic             run, frame_last, pat_on, rd;
  logic [PIX_W-1:0] pix_d;
  logic             vsync_q, hsync_q, valid_q, done_q, uflow_q;
  logic [PIX_W-1:0] data_q;

  img_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (run),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .hs_o    (hs),
    .vs_o    (vs),
    .act_o   (act)
  );

  assign run        = (state_q == RUN);
  assign frame_last = (h_cnt == HW'(H_TOTAL - 1)) && (v_cnt == VW'(V_TOTAL - 1));

`ifdef IMG_STREAM_TX_PATTERN_EN
  logic             pat_q;
  logic [PIX_W-1:0] pat_val;
  // Modulo-2^PIX_W arithmetic gives the truncated sum of row and column offsets.
  assign pat_val = PIX_W'(h_cnt) + PIX_W'(v_cnt) - PIX_W'(H_SYNC + H_BP + V_SYNC + V_BP);
  assign pat_on  = pat_q;
`else
  assign pat_on  = 1'b0;
`endif

  assign rd         = run & act & ~bus.src_empty & ~pat_on;
  assign bus.src_rd = rd;

  always_comb begin
    pix_d = '0;
    if (rd) pix_d = bus.src_data;
`ifdef IMG_STREAM_TX_PATTERN_EN
    if (run && act && pat_on) pix_d = pat_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      uflow_q <= 1'b0;
`ifdef IMG_STREAM_TX_PATTERN_EN
      pat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.enable) begin
          state_q <= RUN;
`ifdef IMG_STREAM_TX_PATTERN_EN
          pat_q   <= bus.pattern_sel;
`endif
        end
        RUN: if (frame_last) begin
          if (!bus.enable) state_q <= IDLE;
`ifdef IMG_STREAM_TX_PATTERN_EN
          else pat_q <= bus.pattern_sel;
`endif
        end
        default: state_q <= IDLE;
      endcase
      vsync_q <= run & vs;
      hsync_q <= run & hs;
      valid_q <= run & act;
      data_q  <= pix_d;
      done_q  <= run & frame_last;
      // An empty FIFO never stretches the frame: the pixel goes out as zero and is flagged.
      uflow_q <= uflow_q | (run & act & bus.src_empty & ~pat_on);
    end
  end

  assign bus.post_img_vsync = vsync_q;
  assign bus.post_img_hsync = hsync_q;
  assign bus.post_img_valid = valid_q;
  assign bus.post_img_data  = data_q;
  assign bus.frame_done     = done_q;
  assign bus.underflow      = uflow_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Scoreboard bench for img_stream_tx on a 7x6 raster: stimulus pushes stamped expected output words,
// a monitor pops and compares them each cycle and checks FIFO pops against the next output.
module tb_img_stream_tx;
  import img_stream_pkg::*;

  localparam int HT = 7;
  localparam int VT = 6;

  typedef struct {
    int          stamp;
    logic [12:0] w;
  } exp_t;

  logic clk;
  logic rst_n;
  img_stream_tx_if bus ();

  img_stream_tx #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  logic [7:0] fifo[$];
  logic [7:0] pix_src[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         pops = 0;
  int         force_stamp = -1;
  logic       pend = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [12:0] mk(input logic vs, input logic hs, input logic va,
                                     input logic [7:0] d, input logic fd, input logic uf);
    return {vs, hs, va, d, fd, uf};
  endfunction

  // Expected raster: counter state c is seen at the outputs on stamp stamp0 + c.
  task automatic push_frame(input int stamp0, input int ncyc, input int starve,
                            input logic uf0, input logic pat);
    int         h, v, idx;
    logic       a, uf;
    logic [7:0] d;
    exp_t       e;
    idx = 0;
    uf  = uf0;
    for (int c = 0; c < ncyc; c++) begin
      h = c % HT;
      v = c / HT;
      a = (h >= 2) && (h < 6) && (v >= 2) && (v < 5);
      d = 8'h00;
      if (a) begin
        if (pat) d = 8'((h - 2) + (v - 2));
        else if (idx == starve) uf = 1'b1;
        else if (pix_src.size() > 0) d = pix_src.pop_front();
        idx++;
      end
      e.stamp = stamp0 + c;
      e.w = mk(v < 1, h < 1, a, d, c == HT * VT - 1, uf);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int stamp0, input int n, input logic uf);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.stamp = stamp0 + i;
      e.w = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, uf);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int s);
    while (cyc < s) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // FWFT FIFO model: pop at the edge where src_rd was high; force_stamp starves one cycle.
  initial begin
    bus.src_empty = 1'b1;
    bus.src_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (pend && fifo.size() > 0) begin
        void'(fifo.pop_front());
        pops++;
      end
      bus.src_empty = (fifo.size() == 0) || (cyc == force_stamp);
      bus.src_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      #1 pend = bus.src_rd & rst_n;
    end
  end

  initial begin : monitor
    logic        prev_rd;
    logic [7:0]  prev_data;
    logic [12:0] got;
    exp_t        e;
    prev_rd   = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      got = {bus.post_img_vsync, bus.post_img_hsync, bus.post_img_valid,
             bus.post_img_data, bus.frame_done, bus.underflow};
      if (prev_rd) begin
        n_cmp++;
        if (!(bus.post_img_valid && bus.post_img_data == prev_data)) begin
          n_fail++;
          $display("FAIL fetch_latency @%0d: valid=%b data=%h, required valid=1 data=%h",
                   cyc, bus.post_img_valid, bus.post_img_data, prev_data);
        end
      end
      prev_rd   = bus.src_rd & rst_n;
      prev_data = bus.src_data;
      while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (e.stamp < cyc) begin
          n_fail++;
          $display("FAIL missed_stamp: stamp %0d not checked, now %0d", e.stamp, cyc);
        end else if (got !== e.w) begin
          n_fail++;
          $display("FAIL out @%0d: got vs/hs/va/data/fd/uf=%b/%b/%b/%h/%b/%b, required %b/%b/%b/%h/%b/%b",
                   cyc, got[12], got[11], got[10], got[9:2], got[1], got[0],
                   e.w[12], e.w[11], e.w[10], e.w[9:2], e.w[1], e.w[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout: bench did not finish, stamp %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin : stim
    int k, s;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
`ifdef IMG_STREAM_TX_PATTERN_EN
    bus.pattern_sel = 1'b0;
`endif
    @(negedge clk);
    push_idle(cyc, 1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two back-to-back frames, enable dropped at frame-2 cycle 10; two words must stay in the FIFO.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 12; i++) begin
        fifo.push_back(8'(i));
        pix_src.push_back(8'(i));
      end
    fifo.push_back(8'hAA);
    fifo.push_back(8'hBB);
    bus.enable = 1'b1;
    k = cyc;
    push_frame(k + 2, 42, -1, 1'b0, 1'b0);
    push_frame(k + 44, 42, -1, 1'b0, 1'b0);
    push_idle(k + 86, 10, 1'b0);
    wait_until(k + 53);
    bus.enable = 1'b0;
    wait_until(k + 96);
    check_int("fifo_left_after_stop", fifo.size(), 2);
    check_int("pops_two_frames", pops, 24);

    // Underflow on the sixth active pixel.
    fifo.delete();
    pix_src.delete();
    rst_n = 1'b0;
    @(negedge clk);
    push_idle(cyc, 1, 1'b0);
    rst_n = 1'b1;
    pops  = 0;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      fifo.push_back(8'(20 + i));
      pix_src.push_back(8'(20 + i));
    end
    bus.enable  = 1'b1;
    k           = cyc;
    force_stamp = k + 25;
    push_frame(k + 2, 42, 5, 1'b0, 1'b0);
    push_idle(k + 44, 6, 1'b1);
    wait_until(k + 5);
    bus.enable = 1'b0;
    wait_until(k + 50);
    check_int("fifo_left_underflow", fifo.size(), 0);
    check_int("pops_underflow", pops, 11);

    // Reset mid-line at h=3,v=1, then restart from the top of the frame.
    for (int i = 0; i < 12; i++) begin
      fifo.push_back(8'(8'h40 + i));
      pix_src.push_back(8'(8'h40 + i));
    end
    bus.enable = 1'b1;
    k = cyc;
    push_frame(k + 2, 11, -1, 1'b1, 1'b0);
    wait_until(k + 12);
    rst_n = 1'b0;
    s = cyc;
    push_idle(s + 1, 2, 1'b0);
    push_frame(s + 3, 42, -1, 1'b0, 1'b0);
    push_idle(s + 45, 5, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(s + 8);
    bus.enable = 1'b0;
    wait_until(s + 52);
    check_int("fifo_left_after_reset", fifo.size(), 0);

`ifdef IMG_STREAM_TX_PATTERN_EN
    // Gradient source with an empty FIFO: no pops and no underflow.
    k = pops;
    bus.pattern_sel = 1'b1;
    bus.enable      = 1'b1;
    s = cyc;
    push_frame(s + 2, 42, -1, 1'b0, 1'b1);
    push_idle(s + 44, 5, 1'b0);
    wait_until(s + 5);
    bus.enable      = 1'b0;
    bus.pattern_sel = 1'b0;
    wait_until(s + 50);
    check_int("pattern_pops", pops, k);
`endif

    repeat (2) @(negedge clk);
    check_int("unchecked_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
